ram_stream_fifo_ctrl: RTL
=========================

RAM_STREAM_FIFO_CTRL -- requirements
Module: ram_stream_fifo_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 32: data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 12: RAM address width; depth = 2**AWIDTH.
REQ-003 SHALL have parameter RD_LAT, default 3: cycles from ram_addrb issue to valid ram_dob.
REQ-004 SHALL have port clock, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, DSIZE: write stream data.
REQ-007 SHALL have port in_valid, input, 1: write stream valid.
REQ-008 SHALL have port in_ready, output, 1: write stream ready.
REQ-009 SHALL have port out_data, output, DSIZE: read stream data.
REQ-010 SHALL have port out_valid, output, 1: read stream valid.
REQ-011 SHALL have port out_ready, input, 1: read stream ready.
REQ-012 SHALL have port ram_addra, output, AWIDTH: RAM port A write address.
REQ-013 SHALL have port ram_dia, output, DSIZE: RAM port A write data.
REQ-014 SHALL have port ram_wea, output, 1: RAM port A write enable.
REQ-015 SHALL have port ram_addrb, output, AWIDTH: RAM port B read address.
REQ-016 SHALL have port ram_dob, input, DSIZE: RAM port B read data, valid RD_LAT cycles after address.
REQ-017 SHALL have port count, output, AWIDTH+1: total words held (RAM plus prefetch buffer).

Function
REQ-018 Write accepted on in_valid && in_ready; same cycle ram_wea=1, ram_addra=wr_ptr, ram_dia=in_data (combinational); wr_ptr increments after.
REQ-019 in_ready SHALL be 1 iff count < 2**AWIDTH.
REQ-020 ram_occ = wr_ptr - rd_ptr (AWIDTH+1-bit pointers, MSB wrap flag); RAM empty when equal.
REQ-021 Read issued in a cycle when ram_occ != 0 and inflight + buf_cnt < RD_LAT+1; ram_addrb=rd_ptr[AWIDTH-1:0], rd_ptr increments.
REQ-022 Word written in cycle t SHALL be read-issuable no earlier than t+1 (no same-cycle read/write of one address).
REQ-023 Delay line of RD_LAT valid bits SHALL mark returning data; on arrival ram_dob pushed into prefetch buffer of RD_LAT+1 entries.
REQ-024 out_valid = buffer non-empty; out_data = buffer head; pop on out_valid && out_ready.
REQ-025 Data SHALL emerge in exact write order; no loss or duplication under any valid/ready pattern.
REQ-026 count += 1 on accepted write, -= 1 on pop; simultaneous both: unchanged.
REQ-027 Pointer wrap at 2**AWIDTH SHALL be seamless.
REQ-028 Minimum write-to-out_valid latency: 1 + RD_LAT + 1 cycles on empty FIFO.
REQ-029 Sustained throughput of one word/cycle when out_ready held 1 and input continuously valid.

Reset
REQ-030 On rst_n low, asynchronously: pointers, count, delay line, buffer occupancy cleared; in_ready=0 during reset, 1 from first clock after release; out_valid=0; ram_wea=0.
REQ-031 Reset mid-operation SHALL discard all stored and in-flight words; ram_dob returning after release SHALL be ignored.

Configuration
REQ-032 Macro RAM_FIFO_ALMOST_FULL_EN: when defined, adds parameter AFULL_THR (default 2**AWIDTH-4) and output almost_full, registered, =1 when count >= AFULL_THR, reset 0.
REQ-033 Without RAM_FIFO_ALMOST_FULL_EN, neither the parameter nor the port exist; all other behaviour identical.

Verification
REQ-034 Write 0x11,0x22,0x33 into empty FIFO, out_ready=1 -> out_data 0x11 at cycle RD_LAT+2 after first write, then 0x22,0x33 consecutive.
REQ-035 Write 4096 words (AWIDTH=12) with out_ready=0 -> in_ready=0 once count=4096; count stays 4096; 4097th word not accepted.
REQ-036 Random valid/ready 50% each, 10000 incrementing words -> output sequence identical, count never exceeds 4096.
REQ-037 Fill to 4095, then simultaneous write and pop each cycle for 8192 cycles -> count constant 4095, pointers wrap, data in order.
REQ-038 Assert rst_n low with 3 reads in flight -> out_valid=0, count=0 next cycle; subsequent write 0xAA emerges first.
REQ-039 With RAM_FIFO_ALMOST_FULL_EN, AFULL_THR=4092 -> almost_full rises cycle after count reaches 4092, falls after count drops to 4091.

Source files
------------

// File: rtl/ram_stream_fifo_ctrl.sv
// Stream FIFO controller around an external dual-port RAM with RD_LAT read latency and a prefetch buffer.
// Optional feature: define RAM_FIFO_ALMOST_FULL_EN to add parameter AFULL_THR and a registered almost_full output.
module ram_stream_fifo_ctrl #(
  parameter int DSIZE  = 32,
  parameter int AWIDTH = 12,
  parameter int RD_LAT = 3
`ifdef RAM_FIFO_ALMOST_FULL_EN
  ,
  parameter int AFULL_THR = (1 << AWIDTH) - 4
`endif
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DSIZE-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DSIZE-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] ram_addra,
  output logic [DSIZE-1:0]  ram_dia,
  output logic              ram_wea,
  output logic [AWIDTH-1:0] ram_addrb,
  input  logic [DSIZE-1:0]  ram_dob,
  output logic [AWIDTH:0]   count
`ifdef RAM_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int BDEPTH = RD_LAT + 1;
  localparam int BW     = (BDEPTH > 1) ? $clog2(BDEPTH) : 1;
  localparam int CW     = $clog2(2 * RD_LAT + 3);
  localparam logic [AWIDTH:0] DEPTH_V  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [CW-1:0]   BDEPTH_C = CW'(BDEPTH);

  logic [AWIDTH:0]   r_wr_ptr;
  logic [AWIDTH:0]   r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic              r_in_ready;
  logic [RD_LAT-1:0] r_dl;
  logic [DSIZE-1:0]  r_buf [BDEPTH];
  logic [BW-1:0]     r_head;
  logic [BW-1:0]     r_tail;
  logic [CW-1:0]     r_bcnt;

  logic [AWIDTH:0]   w_occ;
  logic [AWIDTH:0]   w_count_nxt;
  logic [CW-1:0]     w_inflight;
  logic [CW-1:0]     w_pending;
  logic              w_wr;
  logic              w_pop;
  logic              w_rd;
  logic              w_arrive;

  function automatic logic [BW-1:0] buf_inc(input logic [BW-1:0] p);
    return (p == BW'(BDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr        = in_valid && r_in_ready;
  assign w_pop       = (r_bcnt != '0) && out_ready;
  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_arrive    = r_dl[RD_LAT-1];
  assign w_count_nxt = r_count + (AWIDTH+1)'(w_wr) - (AWIDTH+1)'(w_pop);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_dl[i]);
    end
  end

  // Reserve a buffer slot for every read in flight; the slot freed by this cycle's pop is reusable at once.
  assign w_pending = w_inflight + r_bcnt - CW'(w_pop);
  assign w_rd      = (w_occ != '0) && (w_pending < BDEPTH_C);

  assign ram_wea   = w_wr;
  assign ram_addra = r_wr_ptr[AWIDTH-1:0];
  assign ram_dia   = in_data;
  assign ram_addrb = r_rd_ptr[AWIDTH-1:0];

  assign in_ready  = r_in_ready;
  assign out_valid = (r_bcnt != '0);
  assign out_data  = r_buf[r_head];
  assign count     = r_count;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_dl       <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_bcnt     <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + (AWIDTH+1)'(w_wr);
      r_rd_ptr   <= r_rd_ptr + (AWIDTH+1)'(w_rd);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < DEPTH_V);
      r_dl       <= (r_dl << 1) | RD_LAT'(w_rd);
      if (w_arrive) r_tail <= buf_inc(r_tail);
      if (w_pop)    r_head <= buf_inc(r_head);
      r_bcnt     <= r_bcnt + CW'(w_arrive) - CW'(w_pop);
    end
  end

  // Buffer storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_arrive) r_buf[r_tail] <= ram_dob;
  end

`ifdef RAM_FIFO_ALMOST_FULL_EN
  logic r_afull;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_afull <= 1'b0;
    else        r_afull <= (r_count >= (AWIDTH+1)'(AFULL_THR));
  end

  assign almost_full = r_afull;
`endif

endmodule
